add_accum: RTL and testbench

ADD_ACCUM -- requirements
Module: add_accum

---
 rtl/add_accum_pkg.sv | 20 ++
 rtl/add_accum_if.sv | 28 ++
 rtl/add_accum_step.sv | 30 +++
 rtl/add_accum.sv | 120 ++++++++++++
 tb/tb_add_accum.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/add_accum_pkg.sv
// add_pkg: shared types and constants for the add_accum slice.
//   state_t : frame FSM states (IDLE, ACCUM, HOLD)
//   IN_W    : width of one sample, {carry, sum[3:0]}
package add_pkg;

   localparam int unsigned IN_W  = 5;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Pack the adder-stage outputs into one unsigned sample.
   function automatic logic [IN_W-1:0] sample_of(input logic carry, input logic [3:0] sum);
      return {carry, sum};
   endfunction

endpackage

// File: rtl/add_accum_if.sv
// add_accum_if: sample input and frame-result output handshakes of add_accum.
//   in_valid/in_sum/in_carry/in_ready : upstream sample handshake
//   out_valid/out_ready/out_acc/out_ovf : downstream result handshake
//   cnt : samples accepted in the current frame
// Modports: slave = the accumulator, master = the surrounding logic / bench.
interface add_accum_if #(
   parameter int unsigned ACC_W = 8
);
   logic             in_valid;
   logic [3:0]       in_sum;
   logic             in_carry;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic             out_ovf;
   logic [4:0]       cnt;

   modport slave (
      input  in_valid, in_sum, in_carry, out_ready,
      output in_ready, out_valid, out_acc, out_ovf, cnt
   );

   modport master (
      output in_valid, in_sum, in_carry, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf, cnt
   );
endinterface

// File: rtl/add_accum_step.sv
// add_accum_step: combinational accumulate step, acc_next = acc_in + value.
//   acc_in   : current accumulator
//   value    : 5-bit unsigned sample, zero-extended
//   acc_next : next accumulator (wrapping, or saturating when ADD_ACCUM_SAT_EN)
//   step_ovf : this step carried out of bit ACC_W-1 (i.e. wrapped or clipped)
// Macro: ADD_ACCUM_SAT_EN selects saturation at 2^ACC_W-1; default wraps.
module add_accum_step
   import add_pkg::*;
#(
   parameter int unsigned ACC_W = 8
) (
   input  logic [ACC_W-1:0] acc_in,
   input  logic [IN_W-1:0]  value,
   output logic [ACC_W-1:0] acc_next,
   output logic             step_ovf
);

   logic [ACC_W:0] wide;

   always_comb begin
      wide     = {1'b0, acc_in} + {{(ACC_W+1-IN_W){1'b0}}, value};
      step_ovf = wide[ACC_W];
`ifdef ADD_ACCUM_SAT_EN
      acc_next = step_ovf ? '1 : wide[ACC_W-1:0];
`else
      acc_next = wide[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/add_accum.sv
// add_accum: accumulates NSAMP samples {in_carry,in_sum} into an ACC_W-bit
// frame total, then holds the result until the downstream takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous frame abort; zeroes acc/cnt/ovf, returns to IDLE
//   bus   : add_accum_if.slave (sample in, result out, cnt)
// Macro: ADD_ACCUM_SAT_EN (saturating add instead of wrap, in add_accum_step).
module add_accum
   import add_pkg::*;
#(
   parameter int unsigned NSAMP = 4,
   parameter int unsigned ACC_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   add_accum_if.slave  bus
);

   localparam logic [CNT_W-1:0] NSAMP_C = CNT_W'(NSAMP);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic             ovf;
   logic             step_ovf;
   logic [CNT_W-1:0] cnt;
   logic [IN_W-1:0]  value;
   logic             in_ready;
   logic             out_valid;
   logic             accept;
   logic             last_sample;

   assign value       = sample_of(bus.in_carry, bus.in_sum);
   assign accept      = bus.in_valid & in_ready;
   assign last_sample = (cnt + 5'd1) == NSAMP_C;

   add_accum_step #(.ACC_W(ACC_W)) u_step (
      .acc_in   (acc),
      .value    (value),
      .acc_next (acc_next),
      .step_ovf (step_ovf)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; clear wins over any accept or transfer
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = ACCUM;
            ACCUM:   if (accept && last_sample) state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      if (state == HOLD) begin
         in_ready  = 1'b0;
         out_valid = 1'b1;
      end
   end

   // Datapath: the first accept of a frame loads rather than adds, so the
   // previous frame's total stays visible on out_acc until then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc <= {{(ACC_W-IN_W){1'b0}}, value};
                  cnt <= 5'd1;
                  ovf <= 1'b0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= acc_next;
                  cnt <= cnt + 5'd1;
                  ovf <= ovf | step_ovf;
               end
            end
            HOLD: begin
               if (bus.out_ready) cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_acc   = acc;
   assign bus.out_ovf   = ovf;
   assign bus.cnt       = cnt;

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: self-checking bench for add_accum.
//   u_dut4  : NSAMP=4,  ACC_W=6 (small width so random frames overflow)
//   u_dut16 : NSAMP=16, ACC_W=8
// Expected values come from a frame-level model: the accepted samples of the
// open frame are kept in a queue and the total is their plain integer sum,
// reduced by wrap or clip. Honours ADD_ACCUM_SAT_EN.
module tb_add_accum;

   localparam int unsigned NS4   = 4;
   localparam int unsigned W4    = 6;
   localparam int unsigned MAX4  = (1 << W4) - 1;
   localparam int unsigned NS16  = 16;
   localparam int unsigned W16   = 8;
   localparam int unsigned MAX16 = (1 << W16) - 1;

   logic clk = 1'b0;
   logic rst_n;
   logic clr4, clr16;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // model state for u_dut4
   int unsigned mq[$];
   int unsigned m_last_acc;
   bit          m_last_ovf;

   always #5 clk = ~clk;

   add_accum_if #(.ACC_W(W4))  if4 ();
   add_accum_if #(.ACC_W(W16)) if16 ();

   add_accum #(.NSAMP(NS4), .ACC_W(W4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clr4),
      .bus   (if4.slave)
   );

   add_accum #(.NSAMP(NS16), .ACC_W(W16)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clr16),
      .bus   (if16.slave)
   );

   task automatic check(input string tag, input logic [31:0] act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Frame total from the list of accepted samples.
   function automatic void ref_frame(input int unsigned vals[$], input int unsigned maxv,
                                     output int unsigned acc, output bit ovf);
      int unsigned s = 0;
      foreach (vals[i]) s += vals[i];
      ovf = (s > maxv);
`ifdef ADD_ACCUM_SAT_EN
      acc = ovf ? maxv : s;
`else
      acc = s % (maxv + 1);
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      m_last_acc = 0;
      m_last_ovf = 0;
   endtask

   task automatic check_model();
      int unsigned a;
      bit          o;
      bit          holding;
      holding = (mq.size() == NS4);
      if (mq.size() > 0) ref_frame(mq, MAX4, a, o);
      else begin
         a = m_last_acc;
         o = m_last_ovf;
      end
      check("in_ready",  if4.in_ready,  int'(!holding));
      check("out_valid", if4.out_valid, int'(holding));
      check("cnt",       if4.cnt,       mq.size());
      check("out_acc",   if4.out_acc,   a);
      check("out_ovf",   if4.out_ovf,   int'(o));
   endtask

   task automatic model_update(input bit clr, input bit iv, input int unsigned v, input bit ordy);
      if (clr) begin
         model_reset();
      end else if (mq.size() == NS4) begin
         if (ordy) begin
            ref_frame(mq, MAX4, m_last_acc, m_last_ovf);
            mq.delete();
         end
      end else if (iv) begin
         mq.push_back(v);
      end
   endtask

   // One cycle on u_dut4: drive, check outputs against the model, clock, advance model.
   task automatic tick(input bit clr, input bit iv, input int unsigned v, input bit ordy);
      logic [4:0] vb;
      vb           = 5'(v);
      clr4         = clr;
      if4.in_valid = iv;
      if4.in_sum   = vb[3:0];
      if4.in_carry = vb[4];
      if4.out_ready = ordy;
      check_model();
      @(posedge clk);
      model_update(clr, iv, v, ordy);
      #1;
   endtask

   initial begin
      int unsigned a16;
      bit          o16;
      int unsigned q16[$];

      rst_n = 1'b0;
      clr4 = 1'b0; clr16 = 1'b0;
      if4.in_valid = 1'b0; if4.in_sum = '0; if4.in_carry = 1'b0; if4.out_ready = 1'b0;
      if16.in_valid = 1'b0; if16.in_sum = '0; if16.in_carry = 1'b0; if16.out_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_acc",   if4.out_acc,   0);
      check("rst_cnt",   if4.cnt,       0);
      check("rst_ready", if4.in_ready,  1);
      check("rst_valid", if4.out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // NSAMP=16: sixteen samples of 31 overflow an 8-bit accumulator
      if16.in_valid = 1'b1; if16.in_sum = 4'd15; if16.in_carry = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         q16.push_back(31);
      end
      ref_frame(q16, MAX16, a16, o16);
      check("n16_cnt15",   if16.cnt,       15);
      check("n16_acc15",   if16.out_acc,   a16);
      check("n16_valid15", if16.out_valid, 0);
      @(posedge clk); #1;
      if16.in_valid = 1'b0;
      q16.push_back(31);
      ref_frame(q16, MAX16, a16, o16);
`ifdef ADD_ACCUM_SAT_EN
      check("n16_acc_const", if16.out_acc, 255);
`else
      check("n16_acc_const", if16.out_acc, 240);
`endif
      check("n16_acc",   if16.out_acc,   a16);
      check("n16_ovf",   if16.out_ovf,   1);
      check("n16_valid", if16.out_valid, 1);
      check("n16_cnt",   if16.cnt,       16);
      if16.out_ready = 1'b1;
      @(posedge clk); #1;
      if16.out_ready = 1'b0;
      check("n16_drain_valid", if16.out_valid, 0);
      check("n16_drain_cnt",   if16.cnt,       0);

      // Basic frame: 2+16+18+14 = 50
      tick(0, 1, 2, 0); tick(0, 1, 16, 0); tick(0, 1, 18, 0); tick(0, 1, 14, 0);
      check("f1_valid", if4.out_valid, 1);
      check("f1_acc",   if4.out_acc,   50);
      check("f1_ovf",   if4.out_ovf,   0);
      check("f1_ready", if4.in_ready,  0);
      // Back-pressure: result stable, offered samples ignored
      for (int i = 0; i < 5; i++) tick(0, 1, 7, 0);
      check("stall_acc", if4.out_acc, 50);
      tick(0, 0, 0, 1);
      check("xfer_valid", if4.out_valid, 0);
      check("xfer_cnt",   if4.cnt,       0);
      check("xfer_acc",   if4.out_acc,   50);

      // Reset mid-frame, between edges
      tick(0, 1, 9, 0); tick(0, 1, 9, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_acc",   if4.out_acc,  0);
      check("mrst_cnt",   if4.cnt,      0);
      check("mrst_ovf",   if4.out_ovf,  0);
      check("mrst_ready", if4.in_ready, 1);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick(0, 1, 1, 0);
      check("post_rst_acc", if4.out_acc, 4);
      tick(0, 0, 0, 1);

      // clear in ACCUM drops the concurrent sample
      tick(0, 1, 5, 0);
      tick(1, 1, 7, 0);
      check("clr_acc", if4.out_acc, 0);
      check("clr_cnt", if4.cnt,     0);
      // clear in HOLD beats the transfer
      for (int i = 0; i < 4; i++) tick(0, 1, 20, 0);
      check("pre_clr_ovf", if4.out_ovf, 1);
      tick(1, 0, 0, 1);
      check("clr_hold_valid", if4.out_valid, 0);
      check("clr_hold_ready", if4.in_ready,  1);
      check("clr_hold_acc",   if4.out_acc,   0);

      // Gapped input 1,2,3,4
      for (int i = 1; i <= 4; i++) begin
         tick(0, 1, i, 0);
         if (i < 4) tick(0, 0, 0, 0);
      end
      check("gap_acc", if4.out_acc, 10);
      check("gap_cnt", if4.cnt,     4);
      tick(0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
              $urandom_range(0, 31), ($urandom_range(0, 1) == 1));
      end
      tick(0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
